// File: rtl/dma_bus_arb_pkg.sv
// dma_bus_arb_pkg: shared arbitration state encoding and default tenure constants
package dma_bus_arb_pkg;
  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_REQ       = 3'd1,
    ARB_WAIT_IDLE = 3'd2,
    ARB_OWN       = 3'd3,
    ARB_RELEASE   = 3'd4
  } arb_state_e;
  localparam int DEF_MAX_BEATS      = 8;
  localparam int DEF_REARB_GAP      = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/dma_bus_arb_sync2.sv
// dma_bus_arb_sync2: two-flop synchronizer, async active-low reset, resets to 1 (negated)
module dma_bus_arb_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_ff;
  // shift the asynchronous input through two flops
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ff <= 2'b11;
    else          r_ff <= {r_ff[0], i_d};
  assign o_q = r_ff[1];
endmodule

// File: rtl/dma_bus_arb.sv
// dma_bus_arb: 68030 bus arbitration sequencer for the SCSI DMA path; optional grant timeout via ARB_TIMEOUT_EN
module dma_bus_arb
  import dma_bus_arb_pkg::*;
#(
  parameter int MAX_BEATS      = DEF_MAX_BEATS,
  parameter int REARB_GAP      = DEF_REARB_GAP,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_dma_req,
  input  logic       i_dma_done,
  input  logic       i_cycle_done,
  input  logic       i_bg_n,
  input  logic       i_as_n,
  input  logic [1:0] i_dsack_n,
  input  logic       i_sterm_n,
  input  logic       i_bgack_n,
  input  logic       i_berr_n,
  output logic       o_br_n,
  output logic       o_bgack_n,
  output logic       o_own_n,
  output logic       o_granted,
  output logic       o_arb_timeout
);
  if (MAX_BEATS < 1 || MAX_BEATS > 255 || REARB_GAP < 0 || REARB_GAP > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("dma_bus_arb: parameter out of range");
  end
  arb_state_e r_state, w_state_nx;
  logic       r_br_n, r_bgack_n, r_own_n, r_granted;
  logic       w_br_n_nx, w_bgack_n_nx, w_own_n_nx, w_granted_nx;
  logic [3:0] r_gap, w_gap_nx;
  logic [7:0] r_beats, w_beats_nx;
  logic       w_bg_s, w_bus_idle, w_exit;
  dma_bus_arb_sync2 u_bg_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_bg_n),
    .o_q    (w_bg_s)
  );
  assign w_bus_idle = i_as_n & (&i_dsack_n) & i_sterm_n & i_bgack_n;
  assign w_exit     = i_dma_done | (i_cycle_done & (r_beats == 8'(MAX_BEATS - 1))) | ~i_berr_n;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_to;
  logic       r_arb_timeout, w_to_pulse;
  // count cycles spent waiting for grant; cleared whenever REQ is left
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_to          <= 8'd0;
      r_arb_timeout <= 1'b0;
    end else begin
      r_to          <= (r_state == ARB_REQ && w_state_nx == ARB_REQ) ? r_to + 8'd1 : 8'd0;
      r_arb_timeout <= w_to_pulse;
    end
  assign o_arb_timeout = r_arb_timeout;
`else
  assign o_arb_timeout = 1'b0;
`endif
  // next state and next registered pin values
  always_comb begin
    w_state_nx   = r_state;
    w_br_n_nx    = r_br_n;
    w_bgack_n_nx = r_bgack_n;
    w_own_n_nx   = r_own_n;
    w_granted_nx = 1'b0;
    w_gap_nx     = r_gap - {3'd0, |r_gap};
    w_beats_nx   = r_beats;
`ifdef ARB_TIMEOUT_EN
    w_to_pulse   = 1'b0;
`endif
    case (r_state)
      ARB_IDLE:
        if (r_gap == 4'd0 && i_dma_req) begin
          w_state_nx = ARB_REQ;
          w_br_n_nx  = 1'b0;
        end
      ARB_REQ:
        if (!i_dma_req) begin
          w_state_nx = ARB_IDLE;
          w_br_n_nx  = 1'b1;
        end else if (!w_bg_s) begin
          w_state_nx = ARB_WAIT_IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (r_to == 8'(TIMEOUT_CYCLES - 1)) begin
          w_state_nx = ARB_IDLE;
          w_br_n_nx  = 1'b1;
          w_to_pulse = 1'b1;
          w_gap_nx   = 4'(REARB_GAP);
`endif
        end
      ARB_WAIT_IDLE:
        if (w_bus_idle) begin
          w_state_nx   = ARB_OWN;
          w_bgack_n_nx = 1'b0;
          w_own_n_nx   = 1'b0;
          w_br_n_nx    = 1'b1;
        end
      ARB_OWN: begin
        w_beats_nx   = r_beats + {7'd0, i_cycle_done};
        w_state_nx   = w_exit ? ARB_RELEASE : ARB_OWN;
        w_granted_nx = ~w_exit;
      end
      ARB_RELEASE: begin
        w_state_nx   = ARB_IDLE;
        w_bgack_n_nx = 1'b1;
        w_own_n_nx   = 1'b1;
        w_gap_nx     = 4'(REARB_GAP);
        w_beats_nx   = 8'd0;
      end
      default: w_state_nx = ARB_IDLE;
    endcase
  end
  // state, counters and all pin outputs registered; pins release asynchronously on reset
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state   <= ARB_IDLE;
      r_br_n    <= 1'b1;
      r_bgack_n <= 1'b1;
      r_own_n   <= 1'b1;
      r_granted <= 1'b0;
      r_gap     <= 4'd0;
      r_beats   <= 8'd0;
    end else begin
      r_state   <= w_state_nx;
      r_br_n    <= w_br_n_nx;
      r_bgack_n <= w_bgack_n_nx;
      r_own_n   <= w_own_n_nx;
      r_granted <= w_granted_nx;
      r_gap     <= w_gap_nx;
      r_beats   <= w_beats_nx;
    end
  assign o_br_n    = r_br_n;
  assign o_bgack_n = r_bgack_n;
  assign o_own_n   = r_own_n;
  assign o_granted = r_granted;
endmodule
